// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern of up to PAT_WIDTH bits.
// Bits are qualified by en. Detection can be overlapping or non-overlapping.
// A saturating counter tallies the matches.
// The match pulse on out is registered: it is high for the one cycle after the
// final bit of a match is accepted.

module seq_detector_param #(
  parameter int PAT_WIDTH = 8,
  parameter int CNT_W     = 8,
  localparam int LEN_W    = $clog2(PAT_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in,
  input  logic                 en,
  input  logic                 cfg_load,
  input  logic [PAT_WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0]     pat_len,
  input  logic                 overlap,
  input  logic                 cnt_clr,
  output logic                 out,
  output logic [CNT_W-1:0]     match_count,
  output logic [LEN_W-1:0]     fill
);

  // Largest value match_count can hold; the counter sticks here instead of wrapping.
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Clamp a requested length to the physical history depth.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] res;
    if (len > LEN_W'(PAT_WIDTH)) begin
      res = LEN_W'(PAT_WIDTH);
    end else begin
      res = len;
    end
    return res;
  endfunction

  // Build a mask with the low 'len' bits set; only those bits take part in a compare.
  function automatic logic [PAT_WIDTH-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [PAT_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < PAT_WIDTH; i++) begin
      if (i < int'(len)) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  // Latched configuration.
  logic [PAT_WIDTH-1:0] pat_r;
  logic [LEN_W-1:0]     len_r;
  logic                 ovl_r;

  // Detection state.
  logic [PAT_WIDTH-1:0] hist_r;
  logic [LEN_W-1:0]     fill_r;
  logic                 out_r;
  logic [CNT_W-1:0]     cnt_r;

  // Combinational helpers and next-state values.
  logic [LEN_W-1:0]     eff_len_s;
  logic [PAT_WIDTH-1:0] mask_s;
  logic [PAT_WIDTH-1:0] hist_shift_s;
  logic [LEN_W-1:0]     fill_inc_s;
  logic                 match_s;
  logic [PAT_WIDTH-1:0] hist_nxt_s;
  logic [LEN_W-1:0]     fill_nxt_s;
  logic                 out_nxt_s;
  logic [CNT_W-1:0]     cnt_nxt_s;
  logic [PAT_WIDTH-1:0] pat_nxt_s;
  logic [LEN_W-1:0]     len_nxt_s;
  logic                 ovl_nxt_s;

  // Evaluate the candidate shift and the match condition for the bit offered this cycle.
  always_comb begin
    eff_len_s    = clamp_len(len_r);
    mask_s       = len_mask(eff_len_s);
    hist_shift_s = {hist_r[PAT_WIDTH-2:0], in};

    // Fill saturates at the effective length; with length 0 it stays at 0.
    if (fill_r < eff_len_s) begin
      fill_inc_s = fill_r + LEN_W'(1);
    end else begin
      fill_inc_s = eff_len_s;
    end

    // A zero-length pattern never matches, even though fill equals L trivially.
    // A load cycle drops the offered bit, so it cannot complete a match.
    if (en && !cfg_load && (eff_len_s != '0) && (fill_inc_s == eff_len_s) &&
        ((hist_shift_s & mask_s) == (pat_r & mask_s))) begin
      match_s = 1'b1;
    end else begin
      match_s = 1'b0;
    end
  end

  // Select the next history, fill, pulse and configuration values.
  // A load takes priority over the bit presented in the same cycle.
  always_comb begin
    hist_nxt_s = hist_r;
    fill_nxt_s = fill_r;
    out_nxt_s  = 1'b0;
    pat_nxt_s  = pat_r;
    len_nxt_s  = len_r;
    ovl_nxt_s  = ovl_r;

    if (cfg_load) begin
      pat_nxt_s  = pattern;
      len_nxt_s  = pat_len;
      ovl_nxt_s  = overlap;
      hist_nxt_s = '0;
      fill_nxt_s = '0;
      out_nxt_s  = 1'b0;
    end else if (en) begin
      out_nxt_s = match_s;
      if (match_s && !ovl_r) begin
        // Non-overlapping: the next match must be built from L fresh bits.
        hist_nxt_s = '0;
        fill_nxt_s = '0;
      end else begin
        // Overlapping, or no match yet: keep the shifted history.
        // After an overlapping match, fill is already saturated at L.
        hist_nxt_s = hist_shift_s;
        fill_nxt_s = fill_inc_s;
      end
    end else begin
      hist_nxt_s = hist_r;
      fill_nxt_s = fill_r;
      out_nxt_s  = 1'b0;
    end
  end

  // Next value of the saturating match counter; a clear wins over a same-cycle match.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (cnt_clr) begin
      cnt_nxt_s = '0;
    end else if (match_s && (cnt_r != CNT_MAX)) begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // State and configuration registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_r  <= '0;
      len_r  <= '0;
      ovl_r  <= 1'b0;
      hist_r <= '0;
      fill_r <= '0;
      out_r  <= 1'b0;
      cnt_r  <= '0;
    end else begin
      pat_r  <= pat_nxt_s;
      len_r  <= len_nxt_s;
      ovl_r  <= ovl_nxt_s;
      hist_r <= hist_nxt_s;
      fill_r <= fill_nxt_s;
      out_r  <= out_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

  assign out         = out_r;
  assign match_count = cnt_r;
  assign fill        = fill_r;

endmodule
